// File: rtl/ras_ckpt_if.sv
// Control and prediction signals between the BPU pipeline stages and the
// checkpointed return address stack.
interface ras_ckpt_if #(
  parameter int ADDR_W    = 32,
  parameter int CKPT_SIZE = 2
);
  logic                 wrb_restart;
  logic                 wrb_commit_call;
  logic                 wrb_commit_ret;
  logic [ADDR_W-1:0]    wrb_link_addr;
  logic                 exe_repair;
  logic [CKPT_SIZE-1:0] exe_repair_tag;
  logic                 fch_predict_call;
  logic                 fch_predict_ret;
  logic [ADDR_W-1:0]    fch_link_addr;
  logic                 fch_ckpt_ready;
  logic [CKPT_SIZE-1:0] fch_ckpt_tag;
  logic                 fch_ras_empty;
  logic [ADDR_W-1:0]    fch_ret_addr;
  logic                 fch_ras_overflow;

  modport master (
    output wrb_restart, wrb_commit_call, wrb_commit_ret, wrb_link_addr,
           exe_repair, exe_repair_tag, fch_predict_call, fch_predict_ret,
           fch_link_addr,
    input  fch_ckpt_ready, fch_ckpt_tag, fch_ras_empty, fch_ret_addr,
           fch_ras_overflow
  );

  modport slave (
    input  wrb_restart, wrb_commit_call, wrb_commit_ret, wrb_link_addr,
           exe_repair, exe_repair_tag, fch_predict_call, fch_predict_ret,
           fch_link_addr,
    output fch_ckpt_ready, fch_ckpt_tag, fch_ras_empty, fch_ret_addr,
           fch_ras_overflow
  );
endinterface

// File: rtl/ras_ckpt.sv
// Return address stack with a speculative fetch copy, a committed writeback
// copy and a FIFO of fetch-side checkpoints for single-cycle mispredict repair.
module ras_ckpt #(
  parameter int RAS_SIZE  = 3,
  parameter int ADDR_W    = 32,
  parameter int CKPT_SIZE = 2
) (
  input logic       clk,
  input logic       reset,
  ras_ckpt_if.slave bus
);
  localparam int RAS_ENTRIES = 1 << RAS_SIZE;
  localparam int CKPTS       = 1 << CKPT_SIZE;
  localparam int EW          = ADDR_W - 1;

  typedef logic [EW-1:0]        entry_t;
  typedef logic [RAS_SIZE-1:0]  tos_t;
  typedef logic [RAS_SIZE:0]    depth_t;
  typedef logic [CKPT_SIZE-1:0] tag_t;
  typedef logic [CKPT_SIZE:0]   cnt_t;

  localparam depth_t DEPTH_FULL = depth_t'(RAS_ENTRIES);
  localparam cnt_t   CNT_FULL   = cnt_t'(CKPTS);

  entry_t fch_entry_q [RAS_ENTRIES];
  entry_t fch_entry_d [RAS_ENTRIES];
  entry_t wrb_entry_q [RAS_ENTRIES];
  entry_t wrb_entry_d [RAS_ENTRIES];
  tos_t   fch_tos_q, fch_tos_d, wrb_tos_q, wrb_tos_d;
  depth_t fch_depth_q, fch_depth_d, wrb_depth_q, wrb_depth_d;

  tos_t   slot_tos_q   [CKPTS];
  tos_t   slot_tos_d   [CKPTS];
  depth_t slot_depth_q [CKPTS];
  depth_t slot_depth_d [CKPTS];
  entry_t slot_entry_q [CKPTS];
  entry_t slot_entry_d [CKPTS];

  tag_t alloc_q, alloc_d, free_q, free_d, rep_cnt;
  cnt_t count_q, count_d;
  logic ovf_q, ovf_d;

  logic ckpt_ready, rel, predict_ok;
  tos_t fch_tos_inc, wrb_tos_inc, rep_tos;
  logic unused_lsb;

  assign ckpt_ready  = (count_q != CNT_FULL);
  assign rel         = (bus.wrb_commit_call | bus.wrb_commit_ret) && (count_q != '0);
  assign predict_ok  = (bus.fch_predict_call | bus.fch_predict_ret) && ckpt_ready;
  assign fch_tos_inc = fch_tos_q + tos_t'(1);
  assign wrb_tos_inc = wrb_tos_q + tos_t'(1);
  assign rep_tos     = slot_tos_q[bus.exe_repair_tag];
  assign unused_lsb  = ^{bus.wrb_link_addr[0], bus.fch_link_addr[0]};

  assign bus.fch_ckpt_ready   = ckpt_ready;
  assign bus.fch_ckpt_tag     = alloc_q;
  assign bus.fch_ras_empty    = (fch_depth_q == '0);
  assign bus.fch_ret_addr     = {fch_entry_q[fch_tos_q], 1'b0};
  assign bus.fch_ras_overflow = ovf_q;

  always_comb begin
    fch_entry_d  = fch_entry_q;
    fch_tos_d    = fch_tos_q;
    fch_depth_d  = fch_depth_q;
    wrb_entry_d  = wrb_entry_q;
    wrb_tos_d    = wrb_tos_q;
    wrb_depth_d  = wrb_depth_q;
    slot_tos_d   = slot_tos_q;
    slot_depth_d = slot_depth_q;
    slot_entry_d = slot_entry_q;
    alloc_d      = alloc_q;
    free_d       = free_q + tag_t'(rel);
    count_d      = count_q - cnt_t'(rel);
    rep_cnt      = bus.exe_repair_tag - free_d;
    ovf_d        = 1'b0;

    if (bus.wrb_commit_call) begin
      wrb_tos_d = wrb_tos_inc;
      wrb_entry_d[wrb_tos_inc] = bus.wrb_link_addr[ADDR_W-1:1];
      if (wrb_depth_q != DEPTH_FULL) wrb_depth_d = wrb_depth_q + depth_t'(1);
    end else if (bus.wrb_commit_ret && wrb_depth_q != '0) begin
      wrb_tos_d   = wrb_tos_q - tos_t'(1);
      wrb_depth_d = wrb_depth_q - depth_t'(1);
    end

    // Restart copies the committed stack as it stood before this cycle's commit.
    if (bus.wrb_restart) begin
      fch_entry_d = wrb_entry_q;
      fch_tos_d   = wrb_tos_q;
      fch_depth_d = wrb_depth_q;
      alloc_d     = free_d;
      count_d     = '0;
    end else if (bus.exe_repair) begin
      fch_tos_d            = rep_tos;
      fch_depth_d          = slot_depth_q[bus.exe_repair_tag];
      fch_entry_d[rep_tos] = slot_entry_q[bus.exe_repair_tag];
      alloc_d              = bus.exe_repair_tag;
      count_d              = cnt_t'(rep_cnt);
    end else if (predict_ok) begin
      slot_tos_d[alloc_q]   = fch_tos_q;
      slot_depth_d[alloc_q] = fch_depth_q;
      slot_entry_d[alloc_q] = fch_entry_q[fch_tos_q];
      alloc_d               = alloc_q + tag_t'(1);
      count_d               = count_q + cnt_t'(1) - cnt_t'(rel);
      if (bus.fch_predict_call) begin
        fch_tos_d = fch_tos_inc;
        fch_entry_d[fch_tos_inc] = bus.fch_link_addr[ADDR_W-1:1];
        if (fch_depth_q != DEPTH_FULL) fch_depth_d = fch_depth_q + depth_t'(1);
        else                           ovf_d       = 1'b1;
      end else if (fch_depth_q != '0) begin
        fch_tos_d   = fch_tos_q - tos_t'(1);
        fch_depth_d = fch_depth_q - depth_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        fch_entry_q[i] <= '0;
        wrb_entry_q[i] <= '0;
      end
      for (int i = 0; i < CKPTS; i++) begin
        slot_tos_q[i]   <= '0;
        slot_depth_q[i] <= '0;
        slot_entry_q[i] <= '0;
      end
      fch_tos_q   <= '0;
      fch_depth_q <= '0;
      wrb_tos_q   <= '0;
      wrb_depth_q <= '0;
      alloc_q     <= '0;
      free_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      fch_entry_q  <= fch_entry_d;
      wrb_entry_q  <= wrb_entry_d;
      slot_tos_q   <= slot_tos_d;
      slot_depth_q <= slot_depth_d;
      slot_entry_q <= slot_entry_d;
      fch_tos_q    <= fch_tos_d;
      fch_depth_q  <= fch_depth_d;
      wrb_tos_q    <= wrb_tos_d;
      wrb_depth_q  <= wrb_depth_d;
      alloc_q      <= alloc_d;
      free_q       <= free_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
    end
  end
endmodule

// File: tb/tb_ras_ckpt.sv
// Scoreboarded bench for ras_ckpt: directed scenarios plus random traffic,
// checked against a stack/checkpoint-queue reference model.
module tb_ras_ckpt;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ras_ckpt_if bus ();
  ras_ckpt dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int          tag;
    int          tos;
    int          dep;
    logic [30:0] ent;
  } ck_t;

  typedef struct {
    logic        empty;
    logic [31:0] ret;
    logic        ready;
    logic [1:0]  tag;
    logic        ovf;
  } exp_t;

  logic [30:0] fe[8];
  logic [30:0] we[8];
  int   ftos, fdep, wtos, wdep, free_tag, nxt_tag;
  bit   movf;
  ck_t  ck[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      fe[i] = '0;
      we[i] = '0;
    end
    ftos = 0; fdep = 0; wtos = 0; wdep = 0;
    free_tag = 0; nxt_tag = 0; movf = 0;
    ck.delete();
  endfunction

  // Reference: live checkpoints are a FIFO of snapshots; release pops the front.
  function automatic void model_step();
    logic [30:0] ws[8];
    int   wst, wsd, idx;
    bit   ready, rel;
    exp_t e;
    if (reset) model_reset();
    else begin
      ready = (ck.size() != 4);
      ws = we; wst = wtos; wsd = wdep;
      rel = (bus.wrb_commit_call || bus.wrb_commit_ret) && ck.size() > 0;
      if (rel) begin
        void'(ck.pop_front());
        free_tag = (free_tag + 1) % 4;
      end
      if (bus.wrb_commit_call) begin
        wtos = (wtos + 1) % 8;
        we[wtos] = bus.wrb_link_addr[31:1];
        if (wdep < 8) wdep++;
      end else if (bus.wrb_commit_ret && wdep > 0) begin
        wtos = (wtos + 7) % 8;
        wdep--;
      end
      movf = 0;
      if (bus.wrb_restart) begin
        fe = ws; ftos = wst; fdep = wsd;
        ck.delete();
        nxt_tag = free_tag;
      end else if (bus.exe_repair) begin
        idx = -1;
        foreach (ck[i]) if (ck[i].tag == int'(bus.exe_repair_tag)) idx = i;
        if (idx >= 0) begin
          ftos = ck[idx].tos;
          fdep = ck[idx].dep;
          fe[ftos] = ck[idx].ent;
          while (ck.size() > idx) void'(ck.pop_back());
          nxt_tag = int'(bus.exe_repair_tag);
        end
      end else if ((bus.fch_predict_call || bus.fch_predict_ret) && ready) begin
        ck.push_back('{nxt_tag, ftos, fdep, fe[ftos]});
        nxt_tag = (nxt_tag + 1) % 4;
        if (bus.fch_predict_call) begin
          if (fdep == 8) movf = 1;
          else fdep++;
          ftos = (ftos + 1) % 8;
          fe[ftos] = bus.fch_link_addr[31:1];
        end else if (fdep > 0) begin
          ftos = (ftos + 7) % 8;
          fdep--;
        end
      end
    end
    e.empty = (fdep == 0);
    e.ret   = {fe[ftos], 1'b0};
    e.ready = (ck.size() != 4);
    e.tag   = 2'(nxt_tag);
    e.ovf   = movf;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_empty", 32'(bus.fch_ras_empty), 32'(e.empty));
      chk("sb_ret_addr", bus.fch_ret_addr, e.ret);
      chk("sb_ready", 32'(bus.fch_ckpt_ready), 32'(e.ready));
      chk("sb_tag", 32'(bus.fch_ckpt_tag), 32'(e.tag));
      chk("sb_overflow", 32'(bus.fch_ras_overflow), 32'(e.ovf));
    end
  end

  task automatic clr();
    bus.wrb_restart = 0; bus.wrb_commit_call = 0; bus.wrb_commit_ret = 0;
    bus.wrb_link_addr = '0; bus.exe_repair = 0; bus.exe_repair_tag = '0;
    bus.fch_predict_call = 0; bus.fch_predict_ret = 0; bus.fch_link_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic call(input logic [31:0] a);
    clr(); bus.fch_predict_call = 1; bus.fch_link_addr = a; tick();
  endtask

  task automatic do_reset();
    clr(); reset = 1; tick(); reset = 0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_empty"}, 32'(bus.fch_ras_empty), 32'd1);
    chk({nm, "_ret"}, bus.fch_ret_addr, 32'd0);
    chk({nm, "_ready"}, 32'(bus.fch_ckpt_ready), 32'd1);
    chk({nm, "_tag"}, 32'(bus.fch_ckpt_tag), 32'd0);
    chk({nm, "_ovf"}, 32'(bus.fch_ras_overflow), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit rel;
    int lo;
    reset = 1; clr(); model_reset();
    tick();
    do_reset();
    chk_reset_vals("reset");

    // Three speculative calls
    for (int i = 0; i < 3; i++) begin
      chk("t1_tag", 32'(bus.fch_ckpt_tag), 32'(i));
      call(32'h100 * (i + 1));
    end
    chk("t1_ret", bus.fch_ret_addr, 32'h300);
    chk("t1_empty", 32'(bus.fch_ras_empty), 32'd0);

    // Circular overflow, commits keep one checkpoint in flight
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      clr(); bus.fch_predict_call = 1; bus.fch_link_addr = 32'(i * 16);
      bus.wrb_commit_call = (i > 1); tick();
    end
    chk("t2_ovf", 32'(bus.fch_ras_overflow), 32'd1);
    clr(); tick();
    chk("t2_ovf_clr", 32'(bus.fch_ras_overflow), 32'd0);
    for (int k = 9; k >= 2; k--) begin
      chk("t2_pop_ret", bus.fch_ret_addr, 32'(k * 16));
      clr(); bus.fch_predict_ret = 1; bus.wrb_commit_ret = 1; tick();
    end
    chk("t2_empty", 32'(bus.fch_ras_empty), 32'd1);
    clr(); bus.fch_predict_ret = 1; bus.wrb_commit_ret = 1; tick();
    chk("t2_pop_empty", 32'(bus.fch_ras_empty), 32'd1);
    chk("t2_pop_empty_ret", bus.fch_ret_addr, 32'h90);

    // Repair to the checkpoint taken before the pop
    do_reset();
    call(32'h100); call(32'h200);
    clr(); bus.fch_predict_ret = 1; tick();
    call(32'h400);
    clr(); bus.exe_repair = 1; bus.exe_repair_tag = 2'd2; tick();
    chk("t3_ret", bus.fch_ret_addr, 32'h200);
    chk("t3_tag", 32'(bus.fch_ckpt_tag), 32'd2);
    call(32'h500);
    chk("t3_ready", 32'(bus.fch_ckpt_ready), 32'd1);
    call(32'h600);
    chk("t3_full", 32'(bus.fch_ckpt_ready), 32'd0);

    // Checkpoint exhaustion
    do_reset();
    for (int i = 1; i <= 3; i++) call(32'(i * 16));
    clr(); bus.fch_predict_call = 1; bus.fch_link_addr = 32'h40;
    bus.wrb_commit_call = 1; bus.wrb_link_addr = 32'h10; tick();
    chk("t4_same_cycle", 32'(bus.fch_ckpt_ready), 32'd1);
    call(32'h50);
    chk("t4_ready0", 32'(bus.fch_ckpt_ready), 32'd0);
    call(32'h60);
    chk("t4_ignored", bus.fch_ret_addr, 32'h50);
    clr(); bus.fch_predict_call = 1; bus.fch_link_addr = 32'h70;
    bus.wrb_commit_call = 1; bus.wrb_link_addr = 32'h20; tick();
    chk("t4_ignored_rel", bus.fch_ret_addr, 32'h50);
    chk("t4_ready1", 32'(bus.fch_ckpt_ready), 32'd1);

    // Restart from committed stack
    do_reset();
    call(32'h100);
    clr(); bus.wrb_commit_call = 1; bus.wrb_link_addr = 32'h100; tick();
    call(32'h200); call(32'h300); call(32'h400);
    clr(); bus.wrb_restart = 1; tick();
    chk("t5_ret", bus.fch_ret_addr, 32'h100);
    chk("t5_ready", 32'(bus.fch_ckpt_ready), 32'd1);
    chk("t5_tag", 32'(bus.fch_ckpt_tag), 32'd1);
    chk("t5_empty", 32'(bus.fch_ras_empty), 32'd0);

    // Priority collision, then reset over everything
    call(32'h500); call(32'h600);
    clr(); bus.wrb_restart = 1; bus.exe_repair = 1; bus.exe_repair_tag = 2'd2;
    bus.fch_predict_call = 1; bus.fch_link_addr = 32'h700; tick();
    chk("t6_ret", bus.fch_ret_addr, 32'h100);
    chk("t6_tag", 32'(bus.fch_ckpt_tag), 32'd1);
    call(32'h800);
    bus.wrb_restart = 1; bus.wrb_commit_call = 1; bus.wrb_commit_ret = 1;
    bus.wrb_link_addr = 32'hffff_fffe; bus.exe_repair = 1; bus.exe_repair_tag = 2'd1;
    bus.fch_predict_call = 1; bus.fch_predict_ret = 1; bus.fch_link_addr = 32'habcd_0000;
    reset = 1; tick(); reset = 0;
    chk_reset_vals("t6_reset");

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      clr();
      reset = ($urandom_range(299) == 0);
      bus.wrb_restart     = ($urandom_range(39) == 0);
      bus.wrb_commit_call = ($urandom_range(3) == 0);
      bus.wrb_commit_ret  = ($urandom_range(4) == 0);
      bus.wrb_link_addr   = $urandom;
      bus.fch_predict_call = $urandom_range(1);
      bus.fch_predict_ret  = $urandom_range(1);
      bus.fch_link_addr    = $urandom;
      rel = (bus.wrb_commit_call || bus.wrb_commit_ret) && ck.size() > 0;
      lo  = rel ? 1 : 0;
      if ($urandom_range(7) == 0 && ck.size() > lo) begin
        bus.exe_repair = 1;
        bus.exe_repair_tag = 2'(ck[$urandom_range(ck.size() - 1, lo)].tag);
      end
      tick();
    end
    reset = 0; clr();

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
